// File: rtl/rx_pid_decoder_if.sv
// rx_pid_decoder_if: handshake and status bundle between the unstuffer,
// the PID decoder, the protocol FSM and the receive CRC checker.
interface rx_pid_decoder_if #(
  parameter int MAX_DATA_BYTES = 64
);
  localparam int CNT_W = $clog2(8 * MAX_DATA_BYTES + 17);

  logic             abort;
  logic             start_decode;
  logic             end_decode;
  logic             s_in;
  logic             bit_valid;
  logic             err_ack;
  logic             s_out;
  logic             s_out_valid;
  logic             start_crc;
  logic             end_crc;
  logic             crc_sel;
  logic [3:0]       pid;
  logic [1:0]       pkt_type;
  logic             pid_valid;
  logic             pid_error;
  logic             len_error;
  logic [CNT_W-1:0] bit_count;
  logic             dec_idle;

  modport master (
    output abort, start_decode, end_decode,
    output s_in, bit_valid, err_ack,
    input  s_out, s_out_valid, start_crc,
    input  end_crc, crc_sel, pid, pkt_type,
    input  pid_valid, pid_error, len_error,
    input  bit_count, dec_idle
  );

  modport slave (
    input  abort, start_decode, end_decode,
    input  s_in, bit_valid, err_ack,
    output s_out, s_out_valid, start_crc,
    output end_crc, crc_sel, pid, pkt_type,
    output pid_valid, pid_error, len_error,
    output bit_count, dec_idle
  );
endinterface

// File: rtl/rx_pid_decoder.sv
// rx_pid_decoder: deserialises/validates the PID and forwards body bits to CRC.
// Define LENGTH_CHECK_EN to enable packet-length checking (len_error).
module rx_pid_decoder #(
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  rx_pid_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(8 * MAX_DATA_BYTES + 17);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PID,
    S_BODY,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [6:0]       r_sh;
  logic [2:0]       r_pcnt;
  logic             r_started;
  logic             r_s_out;
  logic             r_s_out_valid;
  logic             r_start_crc;
  logic             r_end_crc;
  logic             r_crc_sel;
  logic [3:0]       r_pid;
  logic [1:0]       r_pkt_type;
  logic             r_pid_valid;
  logic             r_pid_error;
  logic             r_len_error;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_dec_idle;

  logic [7:0]       w_byte;
  logic             w_pid_ok;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_len_ok;
  logic             w_over;
  logic             w_hs;

  // PID arrives LSB first; the newest bit enters at the top.
  assign w_byte    = {bus.s_in, r_sh};
  assign w_pid_ok  = (w_byte[7:4] == ~w_byte[3:0]) &&
                     (w_byte[1:0] != 2'b00);
  assign w_cnt_inc = (r_bit_count == CNT_MAX) ?
                     r_bit_count : r_bit_count + 1'b1;

`ifdef LENGTH_CHECK_EN
  localparam logic [CNT_W-1:0] L_TOK = CNT_W'(16);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(8 * MAX_DATA_BYTES + 16);

  always_comb begin
    w_len_ok = 1'b0;
    unique case (r_pkt_type)
      2'b01: w_len_ok = (r_bit_count == L_TOK);
      2'b10: w_len_ok = (r_bit_count == '0);
      2'b11: w_len_ok = (r_bit_count >= L_TOK) &&
                        (r_bit_count[2:0] == 3'd0) &&
                        (r_bit_count <= L_MAX);
      default: w_len_ok = 1'b0;
    endcase
  end

  assign w_over = (r_pkt_type == 2'b11) && (r_bit_count == L_MAX);
  assign w_hs   = (r_pkt_type == 2'b10);
`else
  assign w_len_ok = 1'b1;
  assign w_over   = 1'b0;
  assign w_hs     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sh          <= '0;
      r_pcnt        <= '0;
      r_started     <= 1'b0;
      r_s_out       <= 1'b0;
      r_s_out_valid <= 1'b0;
      r_start_crc   <= 1'b0;
      r_end_crc     <= 1'b0;
      r_crc_sel     <= 1'b0;
      r_pid         <= '0;
      r_pkt_type    <= '0;
      r_pid_valid   <= 1'b0;
      r_pid_error   <= 1'b0;
      r_len_error   <= 1'b0;
      r_bit_count   <= '0;
      r_dec_idle    <= 1'b1;
    end else begin
      r_s_out_valid <= 1'b0;
      r_start_crc   <= 1'b0;
      r_end_crc     <= 1'b0;
      r_pid_valid   <= 1'b0;
      if (bus.abort) begin
        r_state     <= S_IDLE;
        r_sh        <= '0;
        r_pcnt      <= '0;
        r_started   <= 1'b0;
        r_s_out     <= 1'b0;
        r_crc_sel   <= 1'b0;
        r_pid       <= '0;
        r_pkt_type  <= '0;
        r_pid_error <= 1'b0;
        r_len_error <= 1'b0;
        r_bit_count <= '0;
        r_dec_idle  <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start_decode) begin
              r_state     <= S_PID;
              r_sh        <= w_byte[7:1];
              r_pcnt      <= 3'd1;
              r_bit_count <= '0;
              r_pid       <= '0;
              r_pkt_type  <= '0;
              r_crc_sel   <= 1'b0;
              r_started   <= 1'b0;
              r_dec_idle  <= 1'b0;
            end
          end
          S_PID: begin
            if (bus.end_decode) begin
              r_state     <= S_ERR;
              r_pid_error <= 1'b1;
            end else if (bus.bit_valid) begin
              r_sh   <= w_byte[7:1];
              r_pcnt <= r_pcnt + 3'd1;
              if (r_pcnt == 3'd7) begin
                if (w_pid_ok) begin
                  r_state     <= S_BODY;
                  r_pid       <= w_byte[3:0];
                  r_pkt_type  <= w_byte[1:0];
                  r_crc_sel   <= &w_byte[1:0];
                  r_pid_valid <= 1'b1;
                end else begin
                  r_state     <= S_ERR;
                  r_pid_error <= 1'b1;
                end
              end
            end
          end
          S_BODY: begin
            if (bus.end_decode) begin
              r_end_crc <= r_started;
              r_started <= 1'b0;
              if (w_len_ok) begin
                r_state    <= S_IDLE;
                r_dec_idle <= 1'b1;
              end else begin
                r_state     <= S_ERR;
                r_len_error <= 1'b1;
              end
            end else if (bus.bit_valid) begin
              // Over-length DATA or a handshake body aborts the CRC frame.
              if (w_hs || w_over) begin
                r_state     <= S_ERR;
                r_len_error <= 1'b1;
                r_started   <= 1'b0;
              end else begin
                r_s_out       <= bus.s_in;
                r_s_out_valid <= 1'b1;
                r_start_crc   <= ~r_started;
                r_started     <= 1'b1;
                r_bit_count   <= w_cnt_inc;
              end
            end
          end
          S_ERR: begin
            if (bus.err_ack) begin
              r_state     <= S_IDLE;
              r_pid_error <= 1'b0;
              r_len_error <= 1'b0;
              r_dec_idle  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.s_out       = r_s_out;
  assign bus.s_out_valid = r_s_out_valid;
  assign bus.start_crc   = r_start_crc;
  assign bus.end_crc     = r_end_crc;
  assign bus.crc_sel     = r_crc_sel;
  assign bus.pid         = r_pid;
  assign bus.pkt_type    = r_pkt_type;
  assign bus.pid_valid   = r_pid_valid;
  assign bus.pid_error   = r_pid_error;
  assign bus.len_error   = r_len_error;
  assign bus.bit_count   = r_bit_count;
  assign bus.dec_idle    = r_dec_idle;
endmodule

// File: tb/tb_rx_pid_decoder.sv
// tb_rx_pid_decoder: directed and randomized packets checked against
// a packet-level reference model of the receive PID decoder.
`timescale 1ns/1ps
module tb_rx_pid_decoder;
  localparam int MAXB  = 4;
  localparam int CNT_W = $clog2(8 * MAXB + 17);
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_pid_decoder_if #(.MAX_DATA_BYTES(MAXB)) bus();

  rx_pid_decoder #(.MAX_DATA_BYTES(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit q_exp[$];
  bit q_out[$];
  int mon_sc, mon_ec, mon_pv, mon_order;
  logic [3:0] mon_pid;
  logic [1:0] mon_pt;
  logic mon_sel, mon_pe, mon_le;

  always @(negedge clk) begin
    if (bus.s_out_valid) begin
      if (q_out.size() == 0 && !bus.start_crc) mon_order++;
      if (mon_ec != 0) mon_order++;
      q_out.push_back(bus.s_out);
    end
    if (bus.start_crc) begin
      mon_sc++;
      mon_sel = bus.crc_sel;
      if (!bus.s_out_valid || q_out.size() != 1) mon_order++;
    end
    if (bus.end_crc) begin
      mon_ec++;
      if (bus.s_out_valid) mon_order++;
    end
    if (bus.pid_valid) begin
      mon_pv++;
      mon_pid = bus.pid;
      mon_pt  = bus.pkt_type;
    end
    if (bus.pid_error) mon_pe = 1'b1;
    if (bus.len_error) mon_le = 1'b1;
  end

  task automatic mon_clear();
    q_out.delete();
    mon_sc = 0; mon_ec = 0; mon_pv = 0; mon_order = 0;
    mon_pid = '0; mon_pt = '0;
    mon_sel = 1'b0; mon_pe = 1'b0; mon_le = 1'b0;
  endtask

  // Valid PIDs are the 12 nibbles p (p%4 != 0) sent as {15-p, p}.
  function automatic bit pid_ok(input logic [7:0] pb);
    pid_ok = 1'b0;
    for (int p = 0; p < 16; p++)
      if (p % 4 != 0 && pb == 8'(((15 - p) << 4) | p)) pid_ok = 1'b1;
  endfunction

  function automatic int stream_diff();
    int d;
    d = (q_out.size() > q_exp.size()) ? q_out.size() - q_exp.size()
                                      : q_exp.size() - q_out.size();
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++)
      if (q_out[i] != q_exp[i]) d++;
    return d;
  endfunction

  task automatic drive(input logic sd, input logic ed, input logic bv,
                       input logic si, input logic ab, input logic ack);
    bus.start_decode = sd;
    bus.end_decode   = ed;
    bus.bit_valid    = bv;
    bus.s_in         = si;
    bus.abort        = ab;
    bus.err_ack      = ack;
    @(posedge clk);
    #1;
    bus.start_decode = 1'b0;
    bus.end_decode   = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.s_in         = 1'b0;
    bus.abort        = 1'b0;
    bus.err_ack      = 1'b0;
  endtask

  // mode 0: no stalls, 1: random stalls, 2: stall after every bit
  task automatic gap(input int mode);
    if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0))
      drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] pb, input int nb,
                          input int mode);
    bit b;
    q_exp.delete();
    mon_clear();
    drive(1'b1, 1'b0, 1'b1, pb[0], 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      gap(mode);
      drive(1'b0, 1'b0, 1'b1, pb[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < nb; i++) begin
      gap(mode);
      b = 1'($urandom_range(0, 1));
      q_exp.push_back(b);
      drive(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0);
    end
    gap(mode);
    drive(1'b0, 1'b1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.dec_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 1", bus.dec_idle);
    end
    n_cmp++;
    if ({bus.s_out, bus.s_out_valid, bus.start_crc, bus.end_crc,
         bus.crc_sel, bus.pid, bus.pkt_type, bus.pid_valid,
         bus.pid_error, bus.len_error, bus.bit_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: pid=%h type=%b cnt=%0d want all 0",
               bus.pid, bus.pkt_type, bus.bit_count);
    end
  endtask

  task automatic test_ack();
    send_pkt(8'hD2, 0, 0);
    n_cmp++;
    if (mon_pv !== 1 || mon_pid !== 4'h2 || mon_pt !== 2'b10) begin
      n_bad++;
      $display("FAIL ack_pid: pv=%0d pid=%h type=%b want 1 2 10",
               mon_pv, mon_pid, mon_pt);
    end
    n_cmp++;
    if (mon_sc !== 0 || mon_ec !== 0 || q_out.size() !== 0) begin
      n_bad++;
      $display("FAIL ack_nocrc: sc=%0d ec=%0d bits=%0d want 0 0 0",
               mon_sc, mon_ec, q_out.size());
    end
    n_cmp++;
    if (bus.dec_idle !== 1'b1 || mon_pe !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_idle: idle=%b perr=%b want 1 0",
               bus.dec_idle, mon_pe);
    end
  endtask

  task automatic test_token();
    send_pkt(8'h69, 16, 2);
    n_cmp++;
    if (mon_pv !== 1 || mon_pid !== 4'h9 || mon_pt !== 2'b01) begin
      n_bad++;
      $display("FAIL token_pid: pv=%0d pid=%h type=%b want 1 9 01",
               mon_pv, mon_pid, mon_pt);
    end
    n_cmp++;
    if (stream_diff() !== 0) begin
      n_bad++;
      $display("FAIL token_stream: got %0d bits want %0d, diff %0d",
               q_out.size(), q_exp.size(), stream_diff());
    end
    n_cmp++;
    if (mon_sc !== 1 || mon_ec !== 1 || mon_order !== 0 ||
        mon_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL token_crc: sc=%0d ec=%0d ord=%0d sel=%b want 1 1 0 0",
               mon_sc, mon_ec, mon_order, mon_sel);
    end
    n_cmp++;
    if (bus.bit_count !== CNT_W'(16)) begin
      n_bad++;
      $display("FAIL token_count: got %0d want 16", bus.bit_count);
    end
  endtask

  task automatic test_data0();
    send_pkt(8'hC3, 32, 1);
    n_cmp++;
    if (mon_pv !== 1 || mon_pid !== 4'h3 || mon_pt !== 2'b11) begin
      n_bad++;
      $display("FAIL data0_pid: pv=%0d pid=%h type=%b want 1 3 11",
               mon_pv, mon_pid, mon_pt);
    end
    n_cmp++;
    if (stream_diff() !== 0 || mon_sel !== 1'b1 || mon_ec !== 1) begin
      n_bad++;
      $display("FAIL data0_stream: diff=%0d sel=%b ec=%0d want 0 1 1",
               stream_diff(), mon_sel, mon_ec);
    end
    n_cmp++;
    if (bus.bit_count !== CNT_W'(32) || mon_le !== 1'b0) begin
      n_bad++;
      $display("FAIL data0_len: cnt=%0d lerr=%b want 32 0",
               bus.bit_count, mon_le);
    end
  endtask

  task automatic test_bad_pid();
    send_pkt(8'hF3, 16, 0);
    n_cmp++;
    if (mon_pe !== 1'b1 || mon_pv !== 0) begin
      n_bad++;
      $display("FAIL badpid_flag: perr=%b pv=%0d want 1 0", mon_pe, mon_pv);
    end
    n_cmp++;
    if (q_out.size() !== 0 || mon_sc !== 0 || mon_ec !== 0) begin
      n_bad++;
      $display("FAIL badpid_body: bits=%0d sc=%0d ec=%0d want 0 0 0",
               q_out.size(), mon_sc, mon_ec);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.pid_error !== 1'b1 || bus.dec_idle !== 1'b0) begin
      n_bad++;
      $display("FAIL badpid_hold: perr=%b idle=%b want 1 0",
               bus.pid_error, bus.dec_idle);
    end
    bus.err_ack = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.pid_error !== 1'b1 || bus.dec_idle !== 1'b0) begin
      n_bad++;
      $display("FAIL badpid_early: perr=%b idle=%b want 1 0",
               bus.pid_error, bus.dec_idle);
    end
    @(posedge clk);
    #1;
    bus.err_ack = 1'b0;
    n_cmp++;
    if (bus.pid_error !== 1'b0 || bus.dec_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL badpid_clear: perr=%b idle=%b want 0 1",
               bus.pid_error, bus.dec_idle);
    end
  endtask

  task automatic test_short_pid();
    mon_clear();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.pid_error !== 1'b1 || mon_pv !== 0 || q_out.size() !== 0) begin
      n_bad++;
      $display("FAIL short_pid: perr=%b pv=%0d bits=%0d want 1 0 0",
               bus.pid_error, mon_pv, q_out.size());
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.pid_error !== 1'b0 || bus.dec_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL short_ack: perr=%b idle=%b want 0 1",
               bus.pid_error, bus.dec_idle);
    end
  endtask

  task automatic test_abort();
    logic [7:0] pb;
    pb = 8'h69;
    mon_clear();
    drive(1'b1, 1'b0, 1'b1, pb[0], 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b0, 1'b1, pb[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.s_out, bus.s_out_valid, bus.start_crc, bus.end_crc,
         bus.crc_sel, bus.pid, bus.pkt_type, bus.pid_valid,
         bus.pid_error, bus.len_error, bus.bit_count} !== '0 ||
        bus.dec_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_clear: pid=%h cnt=%0d sov=%b idle=%b want 0 0 0 1",
               bus.pid, bus.bit_count, bus.s_out_valid, bus.dec_idle);
    end
    send_pkt(8'hC3, 24, 1);
    n_cmp++;
    if (mon_pv !== 1 || mon_pid !== 4'h3 || stream_diff() !== 0 ||
        bus.bit_count !== CNT_W'(24)) begin
      n_bad++;
      $display("FAIL abort_after: pv=%0d pid=%h diff=%0d cnt=%0d want 1 3 0 24",
               mon_pv, mon_pid, stream_diff(), bus.bit_count);
    end
  endtask

`ifdef LENGTH_CHECK_EN
  task automatic test_length();
    send_pkt(8'h69, 15, 0);
    n_cmp++;
    if (mon_ec !== 1 || mon_le !== 1'b1 || bus.len_error !== 1'b1 ||
        stream_diff() !== 0) begin
      n_bad++;
      $display("FAIL len_token: ec=%0d lerr=%b diff=%0d want 1 1 0",
               mon_ec, bus.len_error, stream_diff());
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pkt(8'hC3, 16 + 8 * (MAXB + 1), 0);
    while (q_exp.size() > 8 * MAXB + 16) void'(q_exp.pop_back());
    n_cmp++;
    if (mon_sc !== 1 || mon_ec !== 0 || bus.len_error !== 1'b1 ||
        stream_diff() !== 0) begin
      n_bad++;
      $display("FAIL len_data_over: sc=%0d ec=%0d lerr=%b diff=%0d want 1 0 1 0",
               mon_sc, mon_ec, bus.len_error, stream_diff());
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pkt(8'hD2, 2, 0);
    n_cmp++;
    if (mon_pv !== 1 || mon_sc !== 0 || q_out.size() !== 0 ||
        bus.len_error !== 1'b1) begin
      n_bad++;
      $display("FAIL len_hshake: pv=%0d sc=%0d bits=%0d lerr=%b want 1 0 0 1",
               mon_pv, mon_sc, q_out.size(), bus.len_error);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] pb;
      int nb;
      int p;
      int exp_cnt;
      bit ok;
      bit has;
      if ($urandom_range(0, 3) == 0) begin
        pb = 8'($urandom);
      end else begin
        p  = $urandom_range(1, 15);
        pb = 8'(((15 - p) << 4) | p);
      end
      ok = pid_ok(pb);
`ifdef LENGTH_CHECK_EN
      case (pb[1:0])
        2'b01:   nb = 16;
        2'b11:   nb = 16 + 8 * int'($urandom_range(0, MAXB));
        default: nb = 0;
      endcase
`else
      nb = $urandom_range(0, 70);
`endif
      send_pkt(pb, nb, 1);
      has     = (nb > 0);
      exp_cnt = (nb > SAT) ? SAT : nb;
      if (ok) begin
        n_cmp++;
        if (mon_pv !== 1 || mon_pid !== pb[3:0] || mon_pt !== pb[1:0]) begin
          n_bad++;
          $display("FAIL rnd_pid[%0d]: pv=%0d pid=%h type=%b want 1 %h %b",
                   k, mon_pv, mon_pid, mon_pt, pb[3:0], pb[1:0]);
        end
        n_cmp++;
        if (stream_diff() !== 0 || mon_order !== 0 ||
            mon_sc !== int'(has) || mon_ec !== int'(has)) begin
          n_bad++;
          $display("FAIL rnd_stream[%0d]: diff=%0d ord=%0d sc=%0d ec=%0d nb=%0d",
                   k, stream_diff(), mon_order, mon_sc, mon_ec, nb);
        end
        n_cmp++;
        if (has && mon_sel !== (pb[1:0] == 2'b11)) begin
          n_bad++;
          $display("FAIL rnd_sel[%0d]: got %b want %b",
                   k, mon_sel, (pb[1:0] == 2'b11));
        end
        n_cmp++;
        if (bus.bit_count !== CNT_W'(exp_cnt) || mon_le !== 1'b0 ||
            mon_pe !== 1'b0 || bus.dec_idle !== 1'b1) begin
          n_bad++;
          $display("FAIL rnd_end[%0d]: cnt=%0d want %0d lerr=%b perr=%b idle=%b",
                   k, bus.bit_count, exp_cnt, mon_le, mon_pe, bus.dec_idle);
        end
      end else begin
        n_cmp++;
        if (bus.pid_error !== 1'b1 || mon_pv !== 0 ||
            q_out.size() !== 0 || mon_sc !== 0) begin
          n_bad++;
          $display("FAIL rnd_bad[%0d]: pb=%h perr=%b pv=%0d bits=%0d",
                   k, pb, bus.pid_error, mon_pv, q_out.size());
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.pid_error !== 1'b0 || bus.dec_idle !== 1'b1) begin
          n_bad++;
          $display("FAIL rnd_ack[%0d]: perr=%b idle=%b want 0 1",
                   k, bus.pid_error, bus.dec_idle);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.abort        = 1'b0;
    bus.start_decode = 1'b0;
    bus.end_decode   = 1'b0;
    bus.s_in         = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.err_ack      = 1'b0;
    mon_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_ack();
    test_token();
    test_data0();
    test_bad_pid();
    test_short_pid();
    test_abort();
`ifdef LENGTH_CHECK_EN
    test_length();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
